// File: rtl/jtgng_rom_sched.sv
// Slot scheduler sharing one 16-bit ROM read port between main, sound, char,
// scroll and object requesters; one-entry address cache each, plus ROM download writes.
module jtgng_rom_sched #(
  parameter logic [21:0] MAIN_BASE = 22'h00000,
  parameter logic [21:0] SND_BASE  = 22'h14000,
  parameter logic [21:0] CHAR_BASE = 22'h18000,
  parameter logic [21:0] SCR_BASE  = 22'h20000,
  parameter logic [21:0] OBJ_BASE  = 22'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic [2:0]  H,
  input  logic [16:0] main_addr,
  input  logic [14:0] snd_addr,
  input  logic [12:0] char_addr,
  input  logic [14:0] scr_addr,
  input  logic [15:0] obj_addr,
  output logic [7:0]  main_dout,
  output logic [7:0]  snd_dout,
  output logic [15:0] char_dout,
  output logic [15:0] scr_dout,
  output logic [15:0] obj_dout,
  output logic        main_ok,
  output logic        snd_ok,
  output logic        char_ok,
  output logic        scr_ok,
  output logic        obj_ok,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_din,
  input  logic        mem_rdy,
  input  logic [15:0] mem_dout,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data
);

  localparam int NREQ = 5;

  typedef enum logic [1:0] {IDLE, WAIT, DL} state_t;
  typedef enum logic [2:0] {REQ_MAIN, REQ_SND, REQ_CHAR, REQ_SCR, REQ_OBJ} req_t;

  state_t          state_q, state_d;
  req_t            cur_q, cur_d, slot;
  logic [16:0]     tag_q  [NREQ];
  logic [16:0]     tag_d  [NREQ];
  logic [15:0]     data_q [NREQ];
  logic [15:0]     data_d [NREQ];
  logic [NREQ-1:0] valid_q, valid_d;
  logic            wr_pend_q, wr_pend_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [21:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_din_q, mem_din_d;

  logic [16:0]     raw  [NREQ];
  logic [21:0]     word [NREQ];
  logic [NREQ-1:0] hit;

  // Raw addresses are the cache tags; main/snd are byte addresses, so the
  // memory word drops bit 0 and bit 0 later picks the byte lane.
  always_comb begin
    raw[REQ_MAIN]  = main_addr;
    raw[REQ_SND]   = {2'd0, snd_addr};
    raw[REQ_CHAR]  = {4'd0, char_addr};
    raw[REQ_SCR]   = {2'd0, scr_addr};
    raw[REQ_OBJ]   = {1'b0, obj_addr};
    word[REQ_MAIN] = MAIN_BASE + {6'd0, main_addr[16:1]};
    word[REQ_SND]  = SND_BASE  + {8'd0, snd_addr[14:1]};
    word[REQ_CHAR] = CHAR_BASE + {9'd0, char_addr};
    word[REQ_SCR]  = SCR_BASE  + {7'd0, scr_addr};
    word[REQ_OBJ]  = OBJ_BASE  + {6'd0, obj_addr};
    for (int i = 0; i < NREQ; i++) begin
      hit[i] = valid_q[i] && (tag_q[i] == raw[i]);
    end
  end

  always_comb begin
    case (H)
      3'd0:    slot = REQ_CHAR;
      3'd1:    slot = REQ_MAIN;
      3'd2:    slot = REQ_SCR;
      3'd3:    slot = REQ_SND;
      3'd4:    slot = REQ_OBJ;
      3'd5:    slot = REQ_MAIN;
      3'd6:    slot = REQ_SCR;
      default: slot = REQ_OBJ;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    wr_pend_d  = wr_pend_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    if (state_q == DL || (state_q == IDLE && downloading)) begin
      state_d = DL;
      valid_d = '0;
      if (wr_pend_q) begin
        if (mem_rdy) wr_pend_d = 1'b0;
      end else if (prog_we) begin
        mem_wr_d   = 1'b1;
        wr_pend_d  = 1'b1;
        mem_addr_d = prog_addr;
        mem_din_d  = prog_data;
      end else if (!downloading) begin
        state_d = IDLE;
      end
    end else if (state_q == IDLE) begin
      if (cen6 && !hit[slot]) begin
        tag_d[slot]   = raw[slot];
        valid_d[slot] = 1'b0;
        cur_d         = slot;
        mem_addr_d    = word[slot];
        mem_rd_d      = 1'b1;
        state_d       = WAIT;
      end
    end else if (state_q == WAIT) begin
      // Slots that come up while waiting are simply not looked at: dropped.
      if (mem_rdy) begin
        if (cur_q == REQ_MAIN || cur_q == REQ_SND)
          data_d[cur_q] = {8'd0, tag_q[cur_q][0] ? mem_dout[15:8] : mem_dout[7:0]};
        else
          data_d[cur_q] = mem_dout;
        valid_d[cur_q] = 1'b1;
        state_d        = IDLE;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= REQ_MAIN;
      valid_q    <= '0;
      wr_pend_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      // NOTE: tag/data are five small registers, not a RAM, so they are reset
      // too; that is what makes every dout read 0 straight after reset.
      for (int i = 0; i < NREQ; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      valid_q    <= valid_d;
      wr_pend_q  <= wr_pend_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

  assign main_dout = data_q[REQ_MAIN][7:0];
  assign snd_dout  = data_q[REQ_SND][7:0];
  assign char_dout = data_q[REQ_CHAR];
  assign scr_dout  = data_q[REQ_SCR];
  assign obj_dout  = data_q[REQ_OBJ];

  // ok compares the live address, so it falls in the same cycle the address moves.
  assign main_ok   = hit[REQ_MAIN];
  assign snd_ok    = hit[REQ_SND];
  assign char_ok   = hit[REQ_CHAR];
  assign scr_ok    = hit[REQ_SCR];
  assign obj_ok    = hit[REQ_OBJ];

endmodule

// File: tb/tb_jtgng_rom_sched.sv
// Bench for jtgng_rom_sched: a latency-programmable memory responder, a free-running
// cen6/H generator, directed scenarios and a random run against an address-map model.
module tb_jtgng_rom_sched;

  localparam logic [21:0] MAIN_BASE = 22'h00000;
  localparam logic [21:0] SND_BASE  = 22'h14000;
  localparam logic [21:0] CHAR_BASE = 22'h18000;
  localparam logic [21:0] SCR_BASE  = 22'h20000;
  localparam logic [21:0] OBJ_BASE  = 22'h30000;

  logic        clk, rst, cen6;
  logic [2:0]  H;
  logic [16:0] main_addr;
  logic [14:0] snd_addr;
  logic [12:0] char_addr;
  logic [14:0] scr_addr;
  logic [15:0] obj_addr;
  logic [7:0]  main_dout, snd_dout;
  logic [15:0] char_dout, scr_dout, obj_dout;
  logic        main_ok, snd_ok, char_ok, scr_ok, obj_ok;
  logic [21:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_din;
  logic        mem_rdy;
  logic [15:0] mem_dout;
  logic        downloading, prog_we;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;

  jtgng_rom_sched dut (
    .clk(clk), .rst(rst), .cen6(cen6), .H(H),
    .main_addr(main_addr), .snd_addr(snd_addr), .char_addr(char_addr),
    .scr_addr(scr_addr), .obj_addr(obj_addr),
    .main_dout(main_dout), .snd_dout(snd_dout), .char_dout(char_dout),
    .scr_dout(scr_dout), .obj_dout(obj_dout),
    .main_ok(main_ok), .snd_ok(snd_ok), .char_ok(char_ok), .scr_ok(scr_ok), .obj_ok(obj_ok),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_rdy(mem_rdy), .mem_dout(mem_dout),
    .downloading(downloading), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  int checks, errors;
  int lat_fix;
  bit lat_rand;
  bit run_cen;
  int strobe_viol;
  int slot_map [8];

  logic [15:0] mem_w [logic [21:0]];
  logic [21:0] rd_log [$];
  logic [21:0] wr_log [$];

  logic [4:0] oks;
  assign oks = {main_ok, snd_ok, char_ok, scr_ok, obj_ok};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // cen6 every fourth clock; H advances after each cen6 cycle.
  initial begin
    int cnt;
    cnt = 0; cen6 = 0; H = 0;
    forever begin
      @(negedge clk);
      if (cen6) H = H + 3'd1;
      cnt++;
      cen6 = run_cen && (cnt % 4 == 0);
    end
  end

  function automatic logic [15:0] mem_val(input logic [21:0] w);
    logic [31:0] t;
    if (mem_w.exists(w)) return mem_w[w];
    t = {10'd0, w} * 32'h9E3779B1;
    return t[31:16] ^ t[15:0];
  endfunction

  // Memory responder: answers each strobe with one mem_rdy pulse after the latency.
  initial begin
    bit          pend, pend_wr;
    int          pend_cnt;
    logic [21:0] pend_addr;
    logic [15:0] pend_din;
    pend = 0; pend_wr = 0; pend_cnt = 0; pend_addr = 0; pend_din = 0;
    mem_rdy = 0; mem_dout = 0;
    forever begin
      @(negedge clk);
      mem_rdy = 0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          pend = 0;
          mem_rdy = 1;
          if (pend_wr) mem_w[pend_addr] = pend_din;
          else mem_dout = mem_val(pend_addr);
        end
      end
      if (mem_rd || mem_wr) begin
        if (pend) strobe_viol++;
        pend = 1; pend_wr = mem_wr; pend_addr = mem_addr; pend_din = mem_din;
        pend_cnt = lat_rand ? int'($urandom_range(1, 8)) : lat_fix;
        if (mem_wr) wr_log.push_back(mem_addr);
        else rd_log.push_back(mem_addr);
      end
    end
  end

  function automatic logic [21:0] req_word(input int r);
    case (r)
      0:       return MAIN_BASE + 22'(main_addr >> 1);
      1:       return SND_BASE + 22'(snd_addr >> 1);
      2:       return CHAR_BASE + 22'(char_addr);
      3:       return SCR_BASE + 22'(scr_addr);
      default: return OBJ_BASE + 22'(obj_addr);
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input logic [21:0] base, input logic [16:0] a);
    logic [15:0] v;
    v = mem_val(base + 22'(a >> 1));
    return a[0] ? v[15:8] : v[7:0];
  endfunction

  function automatic int count_rd(input logic [21:0] a);
    int n;
    n = 0;
    foreach (rd_log[i]) if (rd_log[i] == a) n++;
    return n;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rd(input logic [21:0] a, input int budget, output bit hit);
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cyc(1);
      if (mem_rd && mem_addr == a) hit = 1;
    end
  endtask

  task automatic wait_rdy(input int budget, output bit hit);
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cyc(1);
      if (mem_rdy) hit = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    cyc(4);
    checks++;
    if ({main_dout, snd_dout, char_dout, scr_dout, obj_dout} !== 64'd0) begin
      errors++;
      $display("FAIL reset_dout got %h exp 0", {main_dout, snd_dout, char_dout, scr_dout, obj_dout});
    end
    checks++;
    if (oks !== 5'd0) begin errors++; $display("FAIL reset_ok got %b exp 00000", oks); end
    checks++;
    if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {mem_rd, mem_wr}); end
    checks++;
    if (mem_addr !== 22'd0 || mem_din !== 16'd0) begin
      errors++; $display("FAIL reset_mem_bus got addr %h din %h exp 0", mem_addr, mem_din);
    end
    rst = 0;
  endtask

  task automatic test_char;
    bit hit;
    rd_log.delete();
    wait_rd(22'h18005, 300, hit);
    checks++;
    if (!hit) begin errors++; $display("FAIL char_read no mem_rd at 18005 within budget"); end
    wait_rdy(20, hit);
    checks++;
    if (!hit || char_ok !== 1'b0) begin errors++; $display("FAIL char_ok_early got rdy %0d ok %b exp rdy 1 ok 0", hit, char_ok); end
    cyc(1);
    checks++;
    if (char_ok !== 1'b1 || char_dout !== mem_val(22'h18005)) begin
      errors++; $display("FAIL char_data got ok %b dout %h exp ok 1 dout %h", char_ok, char_dout, mem_val(22'h18005));
    end
    cyc(200);
    checks++;
    if (count_rd(22'h18005) != 1) begin errors++; $display("FAIL char_cached got %0d reads exp 1", count_rd(22'h18005)); end
  endtask

  task automatic test_main_byte;
    bit hit;
    mem_w[22'h00001] = 16'hA55A;
    main_addr = 17'h00003;
    wait_rd(22'h00001, 300, hit);
    wait_rdy(20, hit);
    cyc(1);
    checks++;
    if (main_ok !== 1'b1 || main_dout !== 8'hA5) begin
      errors++; $display("FAIL main_hi got ok %b dout %h exp ok 1 dout a5", main_ok, main_dout);
    end
    main_addr = 17'h00002;
    #1;
    checks++;
    if (main_ok !== 1'b0) begin errors++; $display("FAIL main_ok_drop got %b exp 0", main_ok); end
    wait_rd(22'h00001, 300, hit);
    checks++;
    if (!hit) begin errors++; $display("FAIL main_reread no mem_rd at 000001 within budget"); end
    wait_rdy(20, hit);
    cyc(1);
    checks++;
    if (main_ok !== 1'b1 || main_dout !== 8'h5A) begin
      errors++; $display("FAIL main_lo got ok %b dout %h exp ok 1 dout 5a", main_ok, main_dout);
    end
  endtask

  task automatic test_holdoff;
    bit hit;
    int extra;
    logic [21:0] w_scr, w_snd;
    lat_fix = 12;
    rd_log.delete();
    scr_addr = 15'h0123;
    snd_addr = 15'h0456;
    w_scr = SCR_BASE + 22'h0123;
    w_snd = SND_BASE + 22'h022B;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1);
      if (mem_rd) hit = 1;
    end
    extra = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1);
      if (mem_rd) extra++;
    end
    checks++;
    if (!hit || extra != 0) begin errors++; $display("FAIL holdoff_drop got first %0d extra %0d exp first 1 extra 0", hit, extra); end
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cyc(1);
      if (scr_ok && snd_ok) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL holdoff_served got scr_ok %b snd_ok %b exp 1 1", scr_ok, snd_ok); end
    checks++;
    if (scr_dout !== mem_val(w_scr) || snd_dout !== exp_byte(SND_BASE, {2'b0, snd_addr})) begin
      errors++; $display("FAIL holdoff_data got scr %h snd %h exp scr %h snd %h",
                         scr_dout, snd_dout, mem_val(w_scr), exp_byte(SND_BASE, {2'b0, snd_addr}));
    end
    checks++;
    if (count_rd(w_scr) != 1 || count_rd(w_snd) != 1 || rd_log.size() != 2) begin
      errors++; $display("FAIL holdoff_reads got scr %0d snd %0d total %0d exp 1 1 2",
                         count_rd(w_scr), count_rd(w_snd), rd_log.size());
    end
    lat_fix = 3;
  endtask

  task automatic test_download;
    bit hit;
    lat_fix = 4;
    obj_addr = 16'h0777;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1);
      if (mem_rd) hit = 1;
    end
    downloading = 1;
    wait_rdy(20, hit);
    cyc(3);
    checks++;
    if (obj_dout !== mem_val(OBJ_BASE + 22'h0777) || oks !== 5'd0) begin
      errors++; $display("FAIL dl_entry got obj %h ok %b exp obj %h ok 00000", obj_dout, oks, mem_val(OBJ_BASE + 22'h0777));
    end
    wr_log.delete();
    rd_log.delete();
    prog_we = 1; prog_addr = 22'h20010; prog_data = 16'h1234;
    cyc(1);
    checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 22'h20010 || mem_din !== 16'h1234) begin
      errors++; $display("FAIL dl_write got wr %b rd %b addr %h din %h exp 1 0 020010 1234", mem_wr, mem_rd, mem_addr, mem_din);
    end
    prog_addr = 22'h20011; prog_data = 16'hBEEF;
    cyc(1);
    prog_we = 0;
    checks++;
    if (mem_wr !== 1'b0) begin errors++; $display("FAIL dl_wr_pulse got %b exp 0", mem_wr); end
    cyc(10);
    checks++;
    if (wr_log.size() != 1 || mem_w.exists(22'h20011) || mem_val(22'h20010) !== 16'h1234) begin
      errors++; $display("FAIL dl_ignore got writes %0d second %0d word %h exp 1 0 1234",
                         wr_log.size(), mem_w.exists(22'h20011), mem_val(22'h20010));
    end
    checks++;
    if (oks !== 5'd0 || rd_log.size() != 0) begin errors++; $display("FAIL dl_quiet got ok %b reads %0d exp 00000 0", oks, rd_log.size()); end
    scr_addr = 15'h0010;
    downloading = 0;
    cyc(300);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (count_rd(req_word(r)) != 1) begin
        errors++; $display("FAIL dl_reread req %0d got %0d reads exp 1", r, count_rd(req_word(r)));
      end
    end
    checks++;
    if (rd_log.size() != 5 || oks !== 5'b11111 || scr_dout !== 16'h1234) begin
      errors++; $display("FAIL dl_after got reads %0d ok %b scr %h exp 5 11111 1234", rd_log.size(), oks, scr_dout);
    end
    lat_fix = 3;
  endtask

  task automatic test_reset_mid;
    bit hit;
    int bad;
    int h;
    lat_fix = 5;
    char_addr = 13'h0AAA;
    wait_rd(CHAR_BASE + 22'h0AAA, 300, hit);
    run_cen = 0;
    cyc(1);
    rst = 1;
    cyc(1);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      if ({main_dout, snd_dout, char_dout, scr_dout, obj_dout} !== 64'd0 || oks !== 5'd0 || mem_rd || mem_wr) bad++;
    end
    checks++;
    if (!hit || bad != 0) begin errors++; $display("FAIL rst_mid got read %0d bad_cycles %0d exp 1 0", hit, bad); end
    run_cen = 1;
    hit = 0;
    h = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc(1);
      if (cen6) begin hit = 1; h = int'(H); end
    end
    cyc(1);
    checks++;
    if (!hit || mem_rd !== 1'b1 || mem_addr !== req_word(slot_map[h])) begin
      errors++; $display("FAIL rst_fresh got rd %b addr %h exp 1 %h", mem_rd, mem_addr, req_word(slot_map[h]));
    end
    cyc(200);
    lat_fix = 3;
  endtask

  task automatic test_random;
    int seen [5];
    for (int r = 0; r < 5; r++) seen[r] = 0;
    lat_rand = 1;
    for (int c = 0; c < 10000; c++) begin
      cyc(1);
      checks++;
      if (mem_rd && mem_wr) begin errors++; $display("FAIL rand_overlap got rd 1 wr 1 exp not both at cycle %0d", c); end
      if ($urandom_range(0, 63) == 0) main_addr = 17'($urandom);
      if ($urandom_range(0, 63) == 0) snd_addr  = 15'($urandom);
      if ($urandom_range(0, 63) == 0) char_addr = 13'($urandom);
      if ($urandom_range(0, 63) == 0) scr_addr  = 15'($urandom);
      if ($urandom_range(0, 63) == 0) obj_addr  = 16'($urandom);
      #1;
      if (main_ok) begin
        seen[0]++; checks++;
        if (main_dout !== exp_byte(MAIN_BASE, main_addr)) begin
          errors++; $display("FAIL rand_main got %h exp %h addr %h", main_dout, exp_byte(MAIN_BASE, main_addr), main_addr);
        end
      end
      if (snd_ok) begin
        seen[1]++; checks++;
        if (snd_dout !== exp_byte(SND_BASE, {2'b0, snd_addr})) begin
          errors++; $display("FAIL rand_snd got %h exp %h addr %h", snd_dout, exp_byte(SND_BASE, {2'b0, snd_addr}), snd_addr);
        end
      end
      if (char_ok) begin
        seen[2]++; checks++;
        if (char_dout !== mem_val(req_word(2))) begin
          errors++; $display("FAIL rand_char got %h exp %h addr %h", char_dout, mem_val(req_word(2)), char_addr);
        end
      end
      if (scr_ok) begin
        seen[3]++; checks++;
        if (scr_dout !== mem_val(req_word(3))) begin
          errors++; $display("FAIL rand_scr got %h exp %h addr %h", scr_dout, mem_val(req_word(3)), scr_addr);
        end
      end
      if (obj_ok) begin
        seen[4]++; checks++;
        if (obj_dout !== mem_val(req_word(4))) begin
          errors++; $display("FAIL rand_obj got %h exp %h addr %h", obj_dout, mem_val(req_word(4)), obj_addr);
        end
      end
    end
    lat_rand = 0;
    checks++;
    if (strobe_viol != 0) begin errors++; $display("FAIL strobe_unacked got %0d exp 0", strobe_viol); end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (seen[r] == 0) begin errors++; $display("FAIL rand_ok_seen req %0d got 0 ok samples exp >0", r); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; strobe_viol = 0;
    lat_fix = 3; lat_rand = 0; run_cen = 1;
    slot_map = '{2, 0, 3, 1, 4, 0, 3, 4};
    rst = 1;
    main_addr = 0; snd_addr = 0; char_addr = 13'h0005; scr_addr = 0; obj_addr = 0;
    downloading = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    test_reset;
    test_char;
    test_main_byte;
    test_holdoff;
    test_download;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
